alu_flag_sequencer: RTL and testbench
=====================================

Name: alu_flag_sequencer

Overview:
Sequential counterpart to the combinational ALU in the 8-bit core. Each cycle it consumes the ALU's opcode, carry_out and compareFlag results, and registers the carry flag that feeds back into the ALU's carry_in_shift. It also registers the compare flag, owns the program counter, and resolves conditional branches, load stalls and halt. It sits between instruction fetch/decode and the ALU/register file.

Parameters:
PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
START_ADDR, 0, PC value loaded on reset and on a start pulse.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; forces the reset state immediately.
start  input  1  single-cycle pulse; leaves HALTED and restarts at START_ADDR.
alu_op  input  4  current instruction's ALU opcode: 2/3/4 add/sub, 7 cmp, 8 shift, 14 load, 15 halt.
alu_carry  input  1  ALU carry_out for the current instruction.
alu_cmp  input  2  ALU compareFlag: 11 none, 10 equal, 01 greater, 00 less.
br_en  input  1  current instruction is a conditional branch.
br_cond  input  2  00 equal, 01 greater, 10 less, 11 carry set.
br_target  input  PC_W  absolute branch destination.
mem_ready  input  1  data memory has returned load data.
pc  output  PC_W  current instruction address.
carry_flag  output  1  registered carry; drives the ALU's carry_in_shift.
cmp_flag  output  2  registered compare result.
stall  output  1  high while waiting for a load.
load_we  output  1  single-cycle register-file write strobe for load data.
done  output  1  high while HALTED.
cycle_count  output  16  performance counter; see Optional Feature.

Behaviour:
- Reset values: pc=START_ADDR, carry_flag=0, cmp_flag=2'b11, stall=0, load_we=0, done=0, state=RUN, cycle_count=0.
- States: RUN, LOAD_WAIT, HALTED.
- RUN, alu_op=15: go to HALTED and hold pc. Halt takes priority over br_en. done=1 from the next cycle.
- RUN, alu_op=14: go to LOAD_WAIT and hold pc. stall=1 (combinational from state) while in LOAD_WAIT.
- RUN, any other opcode: update flags and the next pc as below.
- LOAD_WAIT, mem_ready=0: hold pc and both flags.
- LOAD_WAIT, mem_ready=1: load_we=1 in that same cycle; pc <= pc+1; go to RUN. A load takes at least 2 cycles.
- HALTED: all state frozen; br_en and alu_op ignored.
- HALTED, start=1: pc <= START_ADDR, carry_flag=0, cmp_flag=11, go to RUN. start is ignored in the RUN and LOAD_WAIT states.
- Carry update: carry_flag <= alu_carry only when alu_op is 2, 3, 4 or 8 and the state is RUN. Otherwise carry_flag holds.
- Compare update: cmp_flag <= alu_cmp only when alu_op=7 and the state is RUN. Otherwise cmp_flag holds; a value of 11 from the ALU never overwrites outside op 7.
- Branch decision uses the registered flags (values before this cycle's update):
  - cond 00 taken if cmp_flag==10.
  - cond 01 taken if cmp_flag==01.
  - cond 10 taken if cmp_flag==00.
  - cond 11 taken if carry_flag==1.
  - cmp_flag==11 never satisfies conditions 00, 01 or 10.
- Next pc in RUN: br_target if br_en and the branch is taken, else pc+1.
- PC arithmetic is modulo 2^PC_W: pc=all-ones increments to 0 with no error.
- Branch and flag-update opcode in the same cycle: the flag updates and the branch evaluates the old flag.
- Reset asserted during LOAD_WAIT: the load is abandoned and load_we is never pulsed. A late mem_ready after reset is ignored, because RUN does not sample mem_ready.

Optional Feature:
Macro: ALU_FLAG_SEQ_PERF_EN.
- Defined: cycle_count increments every clock cycle while in RUN or LOAD_WAIT. It saturates at 16'hFFFF, holds while HALTED, and clears on reset and on start.
- Undefined: cycle_count is constant 0 and no counter register is synthesized.

Test Plan:
1. Reset with START_ADDR=0, then 5 cycles of alu_op=0 -> pc 0,1,2,3,4,5; carry_flag=0; cmp_flag=11; done=0.
2. alu_op=2 with alu_carry=1, then alu_op=0 with alu_carry=0 -> carry_flag becomes 1 and holds at 1; next cycle br_en=1, br_cond=11, br_target=0x3F0 -> pc=0x3F0.
3. alu_op=7 with alu_cmp=00, then br_en=1, br_cond=00 -> not taken, pc+1; repeat with br_cond=10 -> taken to br_target.
4. alu_op=14 at pc=0x010, mem_ready low for 3 cycles then high -> stall=1 for 4 cycles; load_we=1 only in the mem_ready cycle; pc=0x011 afterward.
5. alu_op=15 with br_en=1 -> pc frozen, done=1, no branch; start pulse -> pc=START_ADDR, done=0, flags reset.
6. pc=0x3FF (PC_W=10), alu_op=0 -> pc=0x000. Assert reset mid-LOAD_WAIT -> immediate pc=0, stall=0, no load_we pulse.

Source files
------------

// File: rtl/alu_flag_sequencer.sv
// alu_flag_sequencer: carry/compare flag registers, program counter, branch
// resolution, load stall and halt control for the 8-bit core.
//
// Optional build macro: ALU_FLAG_SEQ_PERF_EN
//   defined   -> cycle_count is a saturating 16-bit count of active
//                (RUN or LOAD_WAIT) cycles, cleared by reset and start.
//   undefined -> cycle_count is tied to zero and no counter exists.
//
// stall, done and load_we are decoded from the state register; load_we also
// qualifies on mem_ready so the register file writes in the cycle data arrives.

module alu_flag_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic            alu_carry,
    input  logic [1:0]      alu_cmp,
    input  logic            br_en,
    input  logic [1:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic            carry_flag,
    output logic [1:0]      cmp_flag,
    output logic            stall,
    output logic            load_we,
    output logic            done,
    output logic [15:0]     cycle_count
);

    localparam int unsigned CNT_W = 16;

    // FSM encoding
    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_LOAD_WAIT = 2'd1;
    localparam logic [1:0] S_HALTED    = 2'd2;

    // ALU opcodes of interest
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_ADDC  = 4'd4;
    localparam logic [3:0] OP_CMP   = 4'd7;
    localparam logic [3:0] OP_SHIFT = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // ALU compareFlag encoding
    localparam logic [1:0] CMP_NONE = 2'b11;
    localparam logic [1:0] CMP_EQ   = 2'b10;
    localparam logic [1:0] CMP_GT   = 2'b01;
    localparam logic [1:0] CMP_LT   = 2'b00;

    // Branch condition encoding
    localparam logic [1:0] COND_EQ    = 2'b00;
    localparam logic [1:0] COND_GT    = 2'b01;
    localparam logic [1:0] COND_LT    = 2'b10;
    localparam logic [1:0] COND_CARRY = 2'b11;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            carry_q, carry_d;
    logic [1:0]      cmp_q, cmp_d;
    logic            load_we_c;
    logic            carry_upd_c;
    logic            br_taken_c;
    logic [PC_W-1:0] pc_inc_c;

    // Sequential pc increment; wraps modulo 2^PC_W by width truncation.
    assign pc_inc_c = pc_q + PC_W'(1);

    // Opcodes whose ALU carry_out is architecturally visible.
    always_comb begin
        carry_upd_c = 1'b0;
        case (alu_op)
            OP_ADD, OP_SUB, OP_ADDC, OP_SHIFT: carry_upd_c = 1'b1;
            default:                          carry_upd_c = 1'b0;
        endcase
    end

    // Branch condition against the flags as registered before this cycle.
    always_comb begin
        br_taken_c = 1'b0;
        case (br_cond)
            COND_EQ:    br_taken_c = (cmp_q == CMP_EQ);
            COND_GT:    br_taken_c = (cmp_q == CMP_GT);
            COND_LT:    br_taken_c = (cmp_q == CMP_LT);
            COND_CARRY: br_taken_c = carry_q;
            default:    br_taken_c = 1'b0;
        endcase
    end

    // State register and architectural state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= START_PC;
            carry_q <= 1'b0;
            cmp_q   <= CMP_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            cmp_q   <= cmp_d;
        end
    end

    // Next-state, flag, pc and load strobe decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        carry_d   = carry_q;
        cmp_d     = cmp_q;
        load_we_c = 1'b0;
        case (state_q)
            S_RUN: begin
                if (alu_op == OP_HALT) begin
                    // Halt wins over any branch; pc parks on the halt.
                    state_d = S_HALTED;
                end else if (alu_op == OP_LOAD) begin
                    state_d = S_LOAD_WAIT;
                end else begin
                    if (carry_upd_c) begin
                        carry_d = alu_carry;
                    end
                    if (alu_op == OP_CMP) begin
                        cmp_d = alu_cmp;
                    end
                    pc_d = (br_en && br_taken_c) ? br_target : pc_inc_c;
                end
            end
            S_LOAD_WAIT: begin
                if (mem_ready) begin
                    load_we_c = 1'b1;
                    pc_d      = pc_inc_c;
                    state_d   = S_RUN;
                end
            end
            S_HALTED: begin
                if (start) begin
                    pc_d    = START_PC;
                    carry_d = 1'b0;
                    cmp_d   = CMP_NONE;
                    state_d = S_RUN;
                end
            end
            default: begin
                // Unreachable encoding: recover into a clean run state.
                state_d = S_RUN;
            end
        endcase
    end

`ifdef ALU_FLAG_SEQ_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Active-cycle counter: saturates, freezes while halted, clears on start.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_HALTED) begin
            if (start) begin
                cnt_d = '0;
            end
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = CNT_W'(0);
`endif

    // Output mapping.
    assign pc         = pc_q;
    assign carry_flag = carry_q;
    assign cmp_flag   = cmp_q;
    assign stall      = (state_q == S_LOAD_WAIT);
    assign done       = (state_q == S_HALTED);
    assign load_we    = load_we_c;

endmodule

// File: tb/tb_alu_flag_sequencer.sv
// Self-checking bench for alu_flag_sequencer: a vector table of per-cycle
// inputs with hand-derived expectations, a queue scoreboard for post-edge
// state, and a hand-written reset-during-load sequence.

module tb_alu_flag_sequencer;

    localparam int unsigned PC_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [3:0]      alu_op;
    logic            alu_carry;
    logic [1:0]      alu_cmp;
    logic            br_en;
    logic [1:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            mem_ready;
    logic [PC_W-1:0] pc;
    logic            carry_flag;
    logic [1:0]      cmp_flag;
    logic            stall;
    logic            load_we;
    logic            done;
    logic [15:0]     cycle_count;

    alu_flag_sequencer #(.PC_W(PC_W), .START_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alu_op     (alu_op),
        .alu_carry  (alu_carry),
        .alu_cmp    (alu_cmp),
        .br_en      (br_en),
        .br_cond    (br_cond),
        .br_target  (br_target),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .carry_flag (carry_flag),
        .cmp_flag   (cmp_flag),
        .stall      (stall),
        .load_we    (load_we),
        .done       (done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        logic            c;
        logic [1:0]      cm;
        logic            be;
        logic [1:0]      bc;
        logic [PC_W-1:0] bt;
        logic            mr;
        logic            st;
        logic            e_lwe;
        logic            e_stall;
        logic [PC_W-1:0] e_pc;
        logic            e_cf;
        logic [1:0]      e_cmp;
        logic            e_done;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            cf;
        logic [1:0]      cmp;
        logic            dn;
        logic [15:0]     cnt;
    } post_t;

    localparam int NV = 34;
    vec_t  vecs [NV];
    post_t sb_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [3:0] op, input logic c, input logic [1:0] cm,
        input logic be, input logic [1:0] bc, input logic [PC_W-1:0] bt,
        input logic mr, input logic st,
        input logic lwe, input logic stl,
        input logic [PC_W-1:0] epc, input logic ecf, input logic [1:0] ecmp,
        input logic edn);
        vec_t v;
        v.op = op; v.c = c; v.cm = cm; v.be = be; v.bc = bc; v.bt = bt;
        v.mr = mr; v.st = st; v.e_lwe = lwe; v.e_stall = stl;
        v.e_pc = epc; v.e_cf = ecf; v.e_cmp = ecmp; v.e_done = edn;
        return v;
    endfunction

    task automatic check_post(input string tag);
        post_t e;
        if (sb_q.size() == 0) begin
            chk({tag, " sb_empty"}, 32'(1), 32'(0));
            return;
        end
        e = sb_q.pop_front();
        chk({tag, " pc"},          32'(pc),          32'(e.pc));
        chk({tag, " carry_flag"},  32'(carry_flag),  32'(e.cf));
        chk({tag, " cmp_flag"},    32'(cmp_flag),    32'(e.cmp));
        chk({tag, " done"},        32'(done),        32'(e.dn));
        chk({tag, " cycle_count"}, 32'(cycle_count), 32'(e.cnt));
    endtask

    initial begin
        logic [15:0] exp_cnt;
        logic        exp_halted;
        post_t       p;

        //            op     c  cm     be bc     bt       mr st  lwe stl  pc       cf cmp    dn
        vecs[0]  = mk(4'd0,  0, 2'b00, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h001, 0, 2'b11, 0);
        vecs[1]  = mk(4'd0,  0, 2'b00, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h002, 0, 2'b11, 0);
        vecs[2]  = mk(4'd0,  1, 2'b01, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h003, 0, 2'b11, 0);
        vecs[3]  = mk(4'd0,  0, 2'b10, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h004, 0, 2'b11, 0);
        vecs[4]  = mk(4'd0,  0, 2'b00, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h005, 0, 2'b11, 0);
        vecs[5]  = mk(4'd2,  1, 2'b01, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h006, 1, 2'b11, 0);
        vecs[6]  = mk(4'd0,  0, 2'b10, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h007, 1, 2'b11, 0);
        vecs[7]  = mk(4'd0,  0, 2'b00, 1, 2'b11, 10'h3F0, 0, 0,  0,  0,  10'h3F0, 1, 2'b11, 0);
        vecs[8]  = mk(4'd7,  0, 2'b00, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h3F1, 1, 2'b00, 0);
        vecs[9]  = mk(4'd0,  0, 2'b11, 1, 2'b00, 10'h100, 0, 0,  0,  0,  10'h3F2, 1, 2'b00, 0);
        vecs[10] = mk(4'd0,  0, 2'b11, 1, 2'b10, 10'h010, 0, 0,  0,  0,  10'h010, 1, 2'b00, 0);
        vecs[11] = mk(4'd14, 0, 2'b11, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h010, 1, 2'b00, 0);
        vecs[12] = mk(4'd2,  0, 2'b01, 0, 2'b00, 10'h000, 0, 0,  0,  1,  10'h010, 1, 2'b00, 0);
        vecs[13] = mk(4'd7,  0, 2'b01, 1, 2'b10, 10'h3AA, 0, 0,  0,  1,  10'h010, 1, 2'b00, 0);
        vecs[14] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 0, 0,  0,  1,  10'h010, 1, 2'b00, 0);
        vecs[15] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 1, 0,  1,  1,  10'h011, 1, 2'b00, 0);
        vecs[16] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 1, 0,  0,  0,  10'h012, 1, 2'b00, 0);
        vecs[17] = mk(4'd8,  0, 2'b11, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h013, 0, 2'b00, 0);
        vecs[18] = mk(4'd7,  0, 2'b11, 1, 2'b10, 10'h200, 0, 0,  0,  0,  10'h200, 0, 2'b11, 0);
        vecs[19] = mk(4'd0,  0, 2'b10, 1, 2'b00, 10'h300, 0, 0,  0,  0,  10'h201, 0, 2'b11, 0);
        vecs[20] = mk(4'd7,  0, 2'b10, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h202, 0, 2'b10, 0);
        vecs[21] = mk(4'd2,  1, 2'b11, 1, 2'b11, 10'h050, 0, 0,  0,  0,  10'h203, 1, 2'b10, 0);
        vecs[22] = mk(4'd0,  0, 2'b11, 1, 2'b00, 10'h3FF, 0, 0,  0,  0,  10'h3FF, 1, 2'b10, 0);
        vecs[23] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h000, 1, 2'b10, 0);
        vecs[24] = mk(4'd7,  0, 2'b01, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h001, 1, 2'b01, 0);
        vecs[25] = mk(4'd0,  0, 2'b11, 1, 2'b01, 10'h0AA, 0, 0,  0,  0,  10'h0AA, 1, 2'b01, 0);
        vecs[26] = mk(4'd15, 0, 2'b11, 1, 2'b11, 10'h123, 0, 0,  0,  0,  10'h0AA, 1, 2'b01, 1);
        vecs[27] = mk(4'd2,  0, 2'b00, 1, 2'b11, 10'h124, 0, 0,  0,  0,  10'h0AA, 1, 2'b01, 1);
        vecs[28] = mk(4'd7,  0, 2'b00, 0, 2'b00, 10'h000, 1, 0,  0,  0,  10'h0AA, 1, 2'b01, 1);
        vecs[29] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 0, 1,  0,  0,  10'h000, 0, 2'b11, 0);
        vecs[30] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 0, 1,  0,  0,  10'h001, 0, 2'b11, 0);
        vecs[31] = mk(4'd14, 0, 2'b11, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h001, 0, 2'b11, 0);
        vecs[32] = mk(4'd0,  0, 2'b11, 0, 2'b00, 10'h000, 1, 1,  1,  1,  10'h002, 0, 2'b11, 0);
        vecs[33] = mk(4'd14, 0, 2'b11, 0, 2'b00, 10'h000, 0, 0,  0,  0,  10'h002, 0, 2'b11, 0);

        reset = 1'b1; start = 1'b0; alu_op = 4'd0; alu_carry = 1'b0;
        alu_cmp = 2'b11; br_en = 1'b0; br_cond = 2'b00; br_target = '0;
        mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset pc",          32'(pc),          32'(0));
        chk("reset carry_flag",  32'(carry_flag),  32'(0));
        chk("reset cmp_flag",    32'(cmp_flag),    32'(2'b11));
        chk("reset stall",       32'(stall),       32'(0));
        chk("reset load_we",     32'(load_we),     32'(0));
        chk("reset done",        32'(done),        32'(0));
        chk("reset cycle_count", 32'(cycle_count), 32'(0));

        @(negedge clk);
        reset = 1'b0;
        exp_cnt    = 16'd0;
        exp_halted = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            alu_op    = vecs[i].op;
            alu_carry = vecs[i].c;
            alu_cmp   = vecs[i].cm;
            br_en     = vecs[i].be;
            br_cond   = vecs[i].bc;
            br_target = vecs[i].bt;
            mem_ready = vecs[i].mr;
            start     = vecs[i].st;
            #1;
            chk($sformatf("v%0d load_we", i), 32'(load_we), 32'(vecs[i].e_lwe));
            chk($sformatf("v%0d stall", i),   32'(stall),   32'(vecs[i].e_stall));

            if (exp_halted) begin
                if (vecs[i].st) exp_cnt = 16'd0;
            end else if (exp_cnt != 16'hFFFF) begin
                exp_cnt = exp_cnt + 16'd1;
            end
            exp_halted = vecs[i].e_done;

            p.pc  = vecs[i].e_pc;
            p.cf  = vecs[i].e_cf;
            p.cmp = vecs[i].e_cmp;
            p.dn  = vecs[i].e_done;
`ifdef ALU_FLAG_SEQ_PERF_EN
            p.cnt = exp_cnt;
`else
            p.cnt = 16'd0;
`endif
            sb_q.push_back(p);

            @(posedge clk);
            #1;
            check_post($sformatf("v%0d", i));
        end

        // Reset arrives while a load is outstanding: abandon it without a write.
        chk("pre-reset stall", 32'(stall), 32'(1));
        @(negedge clk);
        alu_op = 4'd0; mem_ready = 1'b0; start = 1'b0; br_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midload pc",          32'(pc),          32'(0));
        chk("midload stall",       32'(stall),       32'(0));
        chk("midload load_we",     32'(load_we),     32'(0));
        chk("midload done",        32'(done),        32'(0));
        chk("midload cmp_flag",    32'(cmp_flag),    32'(2'b11));
        chk("midload cycle_count", 32'(cycle_count), 32'(0));
        mem_ready = 1'b1;
        #1;
        chk("late ready in reset load_we", 32'(load_we), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("late ready load_we", 32'(load_we), 32'(0));
        chk("late ready stall",   32'(stall),   32'(0));
        p.pc = 10'h001; p.cf = 1'b0; p.cmp = 2'b11; p.dn = 1'b0;
`ifdef ALU_FLAG_SEQ_PERF_EN
        p.cnt = 16'd1;
`else
        p.cnt = 16'd0;
`endif
        sb_q.push_back(p);
        @(posedge clk);
        #1;
        check_post("post-reset");
        chk("scoreboard drained", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
